// File: rtl/fpga2_dram_wr_ctrl.sv
// fpga2_dram_wr_ctrl: drains the FPGA 2 rx FIFO into a DRAM ring buffer.
// Bursts have a fixed maximum length, and their addresses increment and wrap.
// Ports:
//   FIFO read side: fifo_empty_i, fifo_rdata_i, fifo_count_i, fifo_rd_en_o
//   DRAM cmd:       cmd_valid_o, cmd_ready_i, cmd_addr_o, cmd_len_o
//   DRAM write:     wvalid_o, wready_i, wdata_o, wlast_o
//   DRAM response:  bvalid_i, berr_i
//   Status:         busy_o, err_o, wrap_o, words_o
// Control inputs: enable_i, err_clr_i.
// Optional macro FPGA2_DRAM_WR_FLUSH_EN adds an idle timer.
// When the timer expires, a partial burst is flushed.
module fpga2_dram_wr_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned REGION_WORDS = 4096,
  parameter int unsigned FLUSH_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              err_clr_i,
  input  logic              fifo_empty_i,
  input  logic [31:0]       fifo_rdata_i,
  input  logic [9:0]        fifo_count_i,
  output logic              fifo_rd_en_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [8:0]        cmd_len_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  output logic [31:0]       wdata_o,
  output logic              wlast_o,
  input  logic              bvalid_i,
  input  logic              berr_i,
  output logic              busy_o,
  output logic              err_o,
  output logic              wrap_o,
  output logic [31:0]       words_o
);

  localparam int unsigned OFF_W = $clog2(REGION_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    RESP,
    ERR
  } state_t;

  state_t           state;
  logic [OFF_W-1:0] offset;
  logic [8:0]       beat;
  logic [31:0]      cnt32;
  logic [31:0]      wte;
  logic [31:0]      len_calc;
  logic [31:0]      off_nxt;
  logic [32:0]      words_sum;
  logic             flush_due;
  logic             start;
  logic             beat_acc;
  logic             last_beat;

  assign cnt32 = 32'(fifo_count_i);

  // Length is clipped by queued words, burst size and ring end.
  always_comb begin
    wte      = REGION_WORDS - 32'(offset);
    len_calc = cnt32;
    if (len_calc > BURST_LEN) len_calc = BURST_LEN;
    if (len_calc > wte)       len_calc = wte;
  end

  // A short ring tail starts as soon as it can be filled completely.
  assign start = enable_i && !err_o && (len_calc != 32'd0) &&
                 ((cnt32 >= BURST_LEN) || (cnt32 >= wte) || flush_due);

  assign wvalid_o     = (state == DATA) && !fifo_empty_i;
  assign wdata_o      = (state == DATA) ? fifo_rdata_i : 32'd0;
  assign beat_acc     = wvalid_o && wready_i;
  assign fifo_rd_en_o = beat_acc;
  assign last_beat    = (beat == cmd_len_o - 9'd1);
  assign wlast_o      = (state == DATA) && last_beat;
  assign busy_o       = (state != IDLE);

  assign off_nxt   = 32'(offset) + 32'(cmd_len_o);
  assign words_sum = {1'b0, words_o} + 33'(cmd_len_o);

`ifdef FPGA2_DRAM_WR_FLUSH_EN
  localparam int unsigned FT_W = $clog2(FLUSH_CYCLES + 1);

  logic [FT_W-1:0] flush_tmr;

  assign flush_due = (32'(flush_tmr) >= FLUSH_CYCLES);

  always_ff @(posedge clk) begin
    if (rst || start || fifo_empty_i || (fifo_count_i == 10'd0)) begin
      flush_tmr <= '0;
    end else if ((state == IDLE) && (cnt32 < BURST_LEN) && !flush_due) begin
      flush_tmr <= flush_tmr + FT_W'(1);
    end
  end
`else
  logic unused_flush;

  assign unused_flush = (FLUSH_CYCLES == 0);
  assign flush_due    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      offset      <= '0;
      beat        <= '0;
      cmd_valid_o <= 1'b0;
      cmd_addr_o  <= '0;
      cmd_len_o   <= '0;
      err_o       <= 1'b0;
      wrap_o      <= 1'b0;
      words_o     <= '0;
    end else begin
      wrap_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= CMD;
            cmd_valid_o <= 1'b1;
            cmd_len_o   <= 9'(len_calc);
            cmd_addr_o  <= ADDR_W'(BASE_ADDR) +
                           (ADDR_W'(offset) << 2);
          end
        end
        CMD: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            beat        <= '0;
            state       <= DATA;
          end
        end
        DATA: begin
          if (beat_acc) begin
            if (last_beat) begin
              beat  <= '0;
              state <= RESP;
            end else begin
              beat <= beat + 9'd1;
            end
          end
        end
        RESP: begin
          // The burst is consumed whether or not it failed.
          if (bvalid_i) begin
            if (off_nxt == REGION_WORDS) begin
              offset <= '0;
              wrap_o <= 1'b1;
            end else begin
              offset <= OFF_W'(off_nxt);
            end
            words_o <= words_sum[32] ? 32'hFFFF_FFFF : words_sum[31:0];
            if (berr_i) begin
              err_o <= 1'b1;
              state <= ERR;
            end else begin
              state <= IDLE;
            end
          end
        end
        ERR: begin
          if (err_clr_i) begin
            err_o <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga2_dram_wr_ctrl.sv
// tb_fpga2_dram_wr_ctrl: scoreboard bench for the DRAM ring write controller.
// Ring model: queue of written words plus an offset modulo the region size.
module tb_fpga2_dram_wr_ctrl;

  localparam int          BL   = 16;
  localparam int          RW   = 32;
  localparam int          FC   = 256;
  localparam logic [31:0] BASE = 32'h0000_1000;

  typedef struct packed {
    logic [31:0] addr;
    logic [8:0]  len;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        err_clr;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  logic [9:0]  fifo_count;
  logic        fifo_rd_en_o;
  logic        cmd_valid_o;
  logic        cmd_ready;
  logic [31:0] cmd_addr_o;
  logic [8:0]  cmd_len_o;
  logic        wvalid_o;
  logic        wready;
  logic [31:0] wdata_o;
  logic        wlast_o;
  logic        bvalid;
  logic        berr;
  logic        busy_o;
  logic        err_o;
  logic        wrap_o;
  logic [31:0] words_o;

  fpga2_dram_wr_ctrl #(
    .ADDR_W      (32),
    .BURST_LEN   (BL),
    .BASE_ADDR   (BASE),
    .REGION_WORDS(RW),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable),
    .err_clr_i   (err_clr),
    .fifo_empty_i(fifo_empty),
    .fifo_rdata_i(fifo_rdata),
    .fifo_count_i(fifo_count),
    .fifo_rd_en_o(fifo_rd_en_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready),
    .cmd_addr_o  (cmd_addr_o),
    .cmd_len_o   (cmd_len_o),
    .wvalid_o    (wvalid_o),
    .wready_i    (wready),
    .wdata_o     (wdata_o),
    .wlast_o     (wlast_o),
    .bvalid_i    (bvalid),
    .berr_i      (berr),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .wrap_o      (wrap_o),
    .words_o     (words_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  cmd_t        exp_cmd[$];
  logic [31:0] exp_data[$];
  logic [31:0] fq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // monitor-owned
  int   cyc = 0;
  int   idx = 0;
  int   cur_len = 0;
  int   n_last = 0;
  int   n_wrap = 0;
  int   beats_total = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  logic rd_seen = 1'b0;

  // stimulus-owned
  logic stall;
  logic rand_rdy;
  logic rand_w;
  logic rand_b;
  logic berr_next;
  int   bcnt;
  int   bdelay;
  int   last_done;
  int   m_off;
  int   m_words;
  int   m_wrap;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmd_t c;
    cyc++;
    rd_seen = fifo_rd_en_o;
    if (wrap_o) n_wrap++;
    if (fifo_empty) chk("pop_when_empty", fifo_rd_en_o, 0);
    if (fifo_rd_en_o || wvalid_o)
      chk("pop_vs_beat", fifo_rd_en_o, wvalid_o && wready);
    if (cmd_valid_o && cmd_ready) begin
      if (exp_cmd.size() == 0) begin
        chk("unexpected_cmd", 1, 0);
      end else begin
        c = exp_cmd.pop_front();
        chk("cmd_addr", cmd_addr_o, c.addr);
        chk("cmd_len", cmd_len_o, c.len);
        cur_len = int'(c.len);
      end
      idx = 0;
    end
    if (wvalid_o && wready) begin
      if (idx == 0) first_cyc = cyc;
      if (exp_data.size() == 0) chk("unexpected_beat", 1, 0);
      else chk("wdata", wdata_o, exp_data.pop_front());
      chk("wlast", wlast_o, idx == cur_len - 1);
      beats_total++;
      if (idx == cur_len - 1) begin
        n_last++;
        last_cyc = cyc;
        idx = 0;
      end else begin
        idx++;
      end
    end
    if (rst) idx = 0;
  end

  task automatic upd();
    fifo_empty = (fq.size() == 0) || stall;
    fifo_rdata = (fq.size() > 0) ? fq[0] : 32'd0;
    fifo_count = 10'(fq.size());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_seen && fq.size() > 0) void'(fq.pop_front());
    bvalid = 1'b0;
    berr   = 1'b0;
    if (rst) begin
      bcnt      = 0;
      last_done = n_last;
    end else begin
      if (last_done != n_last) begin
        last_done = n_last;
        bcnt      = rand_b ? $urandom_range(1, 5) : bdelay;
      end
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin
          bvalid = 1'b1;
          berr   = berr_next;
        end
      end
    end
    cmd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    wready    = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
    upd();
  endtask

  task automatic push_words(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fq.push_back(w);
      exp_data.push_back(w);
    end
    upd();
  endtask

  // Ring model: each burst lands at the current offset.
  task automatic expect_burst(input int len);
    cmd_t c;
    c.addr = BASE + 32'(4 * m_off);
    c.len  = 9'(len);
    exp_cmd.push_back(c);
    m_off   = (m_off + len) % RW;
    if (m_off == 0) m_wrap++;
    m_words = m_words + len;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!(exp_data.size() == 0 && exp_cmd.size() == 0 &&
             bcnt == 0 && !bvalid && (!busy_o || err_o)) && k < 400) begin
      tick();
      k++;
    end
    chk({nm, "_done"}, k < 400, 1);
    tick();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_rd_en"}, fifo_rd_en_o, 0);
    chk({nm, "_cmd_valid"}, cmd_valid_o, 0);
    chk({nm, "_cmd_addr"}, cmd_addr_o, 0);
    chk({nm, "_cmd_len"}, cmd_len_o, 0);
    chk({nm, "_wvalid"}, wvalid_o, 0);
    chk({nm, "_wdata"}, wdata_o, 0);
    chk({nm, "_wlast"}, wlast_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_err"}, err_o, 0);
    chk({nm, "_wrap"}, wrap_o, 0);
    chk({nm, "_words"}, words_o, 0);
  endtask

  initial begin
    int k;
    int b0;
    rst = 1'b1; enable = 1'b0; err_clr = 1'b0; stall = 1'b0;
    cmd_ready = 1'b0; wready = 1'b0; bvalid = 1'b0; berr = 1'b0;
    rand_rdy = 1'b0; rand_w = 1'b0; rand_b = 1'b0; berr_next = 1'b0;
    bcnt = 0; bdelay = 3; last_done = 0;
    m_off = 0; m_words = 0; m_wrap = 0;
    upd();
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    enable = 1'b1;

    // full burst, no stalls
    push_words(16);
    expect_burst(16);
    wait_done("full");
    chk("full_consecutive", last_cyc - first_cyc, 15);
    chk("full_words", words_o, m_words);
    chk("full_nowrap", n_wrap, m_wrap);

    // backpressure plus a FIFO underrun mid-burst
    rand_w = 1'b1;
    rand_b = 1'b1;
    push_words(16);
    expect_burst(16);
    repeat (8) tick();
    stall = 1'b1;
    upd();
    tick();
    tick();
    stall = 1'b0;
    upd();
    wait_done("bp");
    chk("bp_words", words_o, m_words);
    chk("bp_wrap", n_wrap, m_wrap);

    // wrapped burst back at the base, slow command channel
    rand_rdy = 1'b1;
    push_words(16);
    expect_burst(16);
    wait_done("wrap3");
    chk("wrap3_words", words_o, m_words);
    chk("wrap3_wrap", n_wrap, m_wrap);
    rand_rdy = 1'b0;
    rand_w   = 1'b0;
    rand_b   = 1'b0;

    // response error holds off further bursts
    berr_next = 1'b1;
    push_words(16);
    expect_burst(16);
    wait_done("err");
    berr_next = 1'b0;
    chk("err_set", err_o, 1);
    chk("err_busy", busy_o, 1);
    chk("err_words", words_o, m_words);
    push_words(16);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("err_hold_cmd", cmd_valid_o, 0);
    end
    expect_burst(16);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    wait_done("errclr");
    chk("errclr_err", err_o, 0);
    chk("errclr_words", words_o, m_words);
    chk("errclr_wrap", n_wrap, m_wrap);

    // reset during the data phase
    push_words(16);
    expect_burst(16);
    b0 = beats_total;
    k = 0;
    while (beats_total < b0 + 7 && k < 200) begin
      tick();
      k++;
    end
    chk("rst_reach_beat7", k < 200, 1);
    rst = 1'b1;
    tick();
    check_zero("rst_mid");
    rst = 1'b0;
    exp_cmd.delete();
    m_off   = 0;
    m_words = 0;
    push_words(16 - fq.size());
    expect_burst(16);
    wait_done("after_rst");
    chk("after_rst_words", words_o, m_words);

    // partial fill: flushed only when the timer exists
    push_words(5);
`ifdef FPGA2_DRAM_WR_FLUSH_EN
    expect_burst(5);
    k = 0;
    while (!cmd_valid_o && k < 400) begin
      tick();
      k++;
    end
    chk("flush_delay", k, FC + 1);
    wait_done("flush");
    chk("flush_words", words_o, m_words);
`else
    k = 0;
    for (int i = 0; i < FC + 40; i++) begin
      tick();
      if (cmd_valid_o) k++;
    end
    chk("no_flush_cmd", k, 0);
    chk("no_flush_words", words_o, m_words);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpga2_dram_wr_ctrl.md
# fpga2_dram_wr_ctrl

Burst write scheduler that drains the FPGA 2 receiver FIFO into a ring-buffer region of DRAM. It watches the FIFO read-side occupancy and issues fixed-length write bursts with auto-incrementing, wrapping addresses. It streams FIFO words onto the DRAM write channel and checks each burst response. It sits between the receiver FIFO read port and the DRAM write port, and replaces the free-running FIFO read enable.

## Interface

Parameters:
- ADDR_W, 32, DRAM byte-address width
- BURST_LEN, 16, maximum beats per burst (1..256)
- BASE_ADDR, 0, ring base byte address; must be 4-byte aligned
- REGION_WORDS, 4096, ring size in 32-bit words; must be a multiple of BURST_LEN
- FLUSH_CYCLES, 256, idle cycles before a partial burst is flushed

Ports:
- clk  in  1  clock; single clock domain shared with the FIFO read side
- rst  in  1  reset; synchronous, active-high
- enable_i  in  1  allows new bursts to start
- err_clr_i  in  1  clears sticky error
- fifo_empty_i  in  1  FIFO empty (first-word-fall-through)
- fifo_rdata_i  in  32  FIFO head word
- fifo_count_i  in  10  FIFO read data count
- fifo_rd_en_o  out  1  FIFO pop
- cmd_valid_o  out  1  burst command valid
- cmd_ready_i  in  1  command accepted
- cmd_addr_o  out  ADDR_W  burst start byte address
- cmd_len_o  out  9  beats in burst (1..BURST_LEN)
- wvalid_o  out  1  write beat valid
- wready_i  in  1  write beat accepted
- wdata_o  out  32  write data
- wlast_o  out  1  final beat of burst
- bvalid_i  in  1  burst response valid
- berr_i  in  1  burst response error, qualified by bvalid_i
- busy_o  out  1  FSM not in IDLE
- err_o  out  1  sticky response error
- wrap_o  out  1  one-cycle pulse when the address wraps to BASE_ADDR
- words_o  out  32  total words written (saturating)

## Operation

- FSM states: IDLE, CMD, DATA, RESP, ERR.
- IDLE → CMD when enable_i && !err_o and either condition holds:
  - fifo_count_i ≥ BURST_LEN;
  - a flush is due (see Configuration).
- Burst length is latched on the IDLE → CMD transition: len = min(fifo_count_i, BURST_LEN, words_to_end), where words_to_end = REGION_WORDS − offset.
- cmd_addr_o = BASE_ADDR + 4·offset. Address and length are held stable while cmd_valid_o is high.
- CMD → DATA on cmd_valid_o && cmd_ready_i.
- DATA:
  - wvalid_o = !fifo_empty_i; wdata_o = fifo_rdata_i.
  - fifo_rd_en_o = wvalid_o && wready_i.
  - The beat counter increments per accepted beat.
  - wlast_o is high on beat len−1.
  - The last accepted beat moves the FSM to RESP.
- RESP:
  - On bvalid_i, offset += len. If the new offset equals REGION_WORDS, offset becomes 0 and wrap_o pulses.
  - words_o += len, saturating at 2^32−1.
  - If berr_i, go to ERR and set err_o. Otherwise go to IDLE.
  - Offset and words_o advance on error too; the burst is consumed from the FIFO either way.
- ERR: stays in ERR until err_clr_i, then returns to IDLE and clears err_o.
- Deasserting enable_i mid-burst does not abort the burst. The burst completes through RESP, then the FSM waits in IDLE.
- fifo_rd_en_o is never asserted outside DATA or while fifo_empty_i is high.

## Timing

- Reset values: all outputs 0 (fifo_rd_en_o, cmd_valid_o, cmd_addr_o, cmd_len_o, wvalid_o, wdata_o, wlast_o, busy_o, err_o, wrap_o, words_o). State is IDLE; offset, beat counter and flush timer are 0.
- cmd_valid_o rises the cycle after the IDLE start condition is sampled.
- DATA begins the cycle after the command handshake. With the FIFO non-empty and wready_i held high, one beat transfers per cycle.
- wrap_o and the words_o update occur in the cycle after bvalid_i is sampled.
- The earliest next cmd_valid_o is 2 cycles after bvalid_i.
- rst asserted in any state returns the FSM to IDLE on the next edge. Outputs and counters return to their reset values; no handshake completion is required.
- bvalid_i outside RESP is ignored.

## Configuration

- FPGA2_DRAM_WR_FLUSH_EN defined:
  - A flush timer counts cycles in IDLE while 0 < fifo_count_i < BURST_LEN.
  - The timer resets on any burst start or when the FIFO is empty.
  - At FLUSH_CYCLES the flush is due and a partial burst of fifo_count_i words (still clipped at the region end) is issued.
- Not defined: the timer is absent. Bursts start only at fifo_count_i ≥ BURST_LEN, except a region-end clip, where a burst starts once fifo_count_i ≥ words_to_end.

## Test plan

- Full burst, zero stalls: 16 words queued, cmd_ready_i and wready_i always high, bvalid_i 3 cycles after wlast_o → cmd_addr_o=BASE_ADDR, cmd_len_o=16, 16 consecutive pops with data in order, wlast_o on beat 16, words_o=16, next cmd_addr_o=BASE_ADDR+64.
- Backpressure: wready_i toggles every cycle and FIFO goes empty for 2 cycles mid-burst → no pop without an accepted beat, 16 beats delivered intact, no duplicated or dropped words.
- Wrap: REGION_WORDS=32, 3 bursts of 16 → addresses BASE, BASE+64, BASE; wrap_o pulses once after the 2nd response.
- Response error: berr_i=1 on the first response → err_o=1, FSM in ERR, no cmd_valid_o despite 16 queued words; err_clr_i → next burst issued at BASE+64.
- Flush (macro defined): 5 words queued, FLUSH_CYCLES=256 → cmd_len_o=5 issued 257 cycles after the count becomes stable. Macro undefined → no command.
- Reset mid-DATA after beat 7 → all outputs 0 next cycle; a subsequent burst starts at BASE_ADDR.
